// File: rtl/sonar_pkg.sv
// Shared sonar definitions: echo timer state encoding and default timing constants.
package sonar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_ISSUE,
    ST_HOLDOFF
  } echo_state_t;

  localparam int unsigned CYCLES_PER_CM  = 5831;
  localparam int unsigned TRIG_CYCLES    = 1000;
  localparam int unsigned TIMEOUT_CYCLES = 3_000_000;
  localparam int unsigned HOLDOFF_CYCLES = 6_000_000;

endpackage

// File: rtl/echo_timer_if.sv
// Launch handshake between the echo timer and the downstream iterative divider.
interface echo_timer_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] div_dividend_out;
  logic [WIDTH-1:0] div_divisor_out;
  logic             div_valid_out;
  logic             div_busy_in;

  modport master (
    output div_dividend_out,
    output div_divisor_out,
    output div_valid_out,
    input  div_busy_in
  );

  modport slave (
    input  div_dividend_out,
    input  div_divisor_out,
    input  div_valid_out,
    output div_busy_in
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, synchronous active-low reset.
module sync_2ff (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d_in,
  output logic q_out
);
  logic meta_p0;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      meta_p0 <= 1'b0;
      q_out   <= 1'b0;
    end else begin
      meta_p0 <= d_in;
      q_out   <= meta_p0;
    end
  end
endmodule

// File: rtl/echo_timer.sv
// Sonar front end: trigger pulse, echo-high measurement, divider launch, timeout and re-ping holdoff.
module echo_timer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TRIG_CYCLES    = sonar_pkg::TRIG_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = sonar_pkg::TIMEOUT_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = sonar_pkg::HOLDOFF_CYCLES,
  parameter int unsigned CYCLES_PER_CM  = sonar_pkg::CYCLES_PER_CM
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             echo_in,
  echo_timer_if.master     div,
  output logic             trigger_out,
  output logic [WIDTH-1:0] tof_cycles_out,
  output logic             timeout_out,
  output logic             busy_out
);
  import sonar_pkg::*;

  localparam logic [WIDTH-1:0] TRIG_LAST = WIDTH'(TRIG_CYCLES - 1);
  localparam logic [WIDTH-1:0] WAIT_LAST = WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH-1:0] MEAS_MAX  = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0] HOLD_LAST = WIDTH'(HOLDOFF_CYCLES - 1);

  echo_state_t      state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tof_q, tof_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic             trig_q, trig_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic             busy_q;
  logic             echo_sync, echo_prev, echo_rise;

  sync_2ff u_echo_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d_in     (echo_in),
    .q_out    (echo_sync)
  );

  assign echo_rise = echo_sync & ~echo_prev;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + WIDTH'(1);
    trig_d     = 1'b0;
    valid_d    = 1'b0;
    tmo_d      = 1'b0;
    tof_d      = tof_q;
    dividend_d = dividend_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_in) begin
          state_d = ST_TRIG;
          trig_d  = 1'b1;
        end
      end
      ST_TRIG: begin
        trig_d = 1'b1;
        if (cnt_q == TRIG_LAST) begin
          state_d = ST_WAIT_RISE;
          cnt_d   = '0;
          trig_d  = 1'b0;
        end
      end
      ST_WAIT_RISE: begin
        if (echo_rise) begin
          state_d = ST_MEASURE;
          cnt_d   = WIDTH'(1);
        end else if (cnt_q == WAIT_LAST) begin
          state_d = ST_HOLDOFF;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end
      end
      // A fall seen on the same cycle the count hits its limit is still a valid reading.
      ST_MEASURE: begin
        if (!echo_sync) begin
          state_d    = ST_ISSUE;
          cnt_d      = '0;
          tof_d      = cnt_q;
          dividend_d = cnt_q;
        end else if (cnt_q == MEAS_MAX) begin
          state_d = ST_HOLDOFF;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        if (!div.div_busy_in) begin
          state_d = ST_HOLDOFF;
          valid_d = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tof_q      <= '0;
      dividend_q <= '0;
      trig_q     <= 1'b0;
      valid_q    <= 1'b0;
      tmo_q      <= 1'b0;
      busy_q     <= 1'b0;
      echo_prev  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tof_q      <= tof_d;
      dividend_q <= dividend_d;
      trig_q     <= trig_d;
      valid_q    <= valid_d;
      tmo_q      <= tmo_d;
      busy_q     <= (state_d != ST_IDLE);
      echo_prev  <= echo_sync;
    end
  end

  assign trigger_out          = trig_q;
  assign tof_cycles_out       = tof_q;
  assign timeout_out          = tmo_q;
  assign busy_out             = busy_q;
  assign div.div_dividend_out = dividend_q;
  assign div.div_divisor_out  = WIDTH'(CYCLES_PER_CM);
  assign div.div_valid_out    = valid_q;
endmodule

// File: doc/echo_timer.md
# echo_timer

- Front end of the sonar ranging path.
- On request, issues an ultrasonic trigger pulse, synchronizes the sensor echo line and measures the echo-high time in clock cycles.
- Hands that count to the downstream iterative divider as dividend, with a constant cycles-per-centimetre divisor, so the divider's quotient is range in cm.
- Handles echo timeout and enforces a re-ping holdoff.

## Interface
Parameters:
- WIDTH, 32, width of counters and divider operands
- TRIG_CYCLES, 1000, trigger_out high time (10 us at 100 MHz)
- TIMEOUT_CYCLES, 3_000_000, max cycles waiting for echo rise, and max echo-high time
- HOLDOFF_CYCLES, 6_000_000, quiet time after each ping before a new start is accepted
- CYCLES_PER_CM, 5831, divisor driven to divider (round-trip cycles per cm); must be ≥ 1

Ports:
- clk_in  input  1  system clock; sole clock domain
- rst_n_in  input  1  synchronous, active-low reset
- start_in  input  1  ping request; sampled only in IDLE
- echo_in  input  1  raw sensor echo, asynchronous; 2-flop synchronized internally
- div_busy_in  input  1  divider busy flag
- trigger_out  output  1  sensor trigger
- div_dividend_out  output  WIDTH  measured echo-high cycles
- div_divisor_out  output  WIDTH  constant CYCLES_PER_CM
- div_valid_out  output  1  one-cycle launch strobe to divider
- tof_cycles_out  output  WIDTH  last valid measurement, held
- timeout_out  output  1  one-cycle pulse on timeout
- busy_out  output  1  high in every state except IDLE

## Operation
States: IDLE, TRIG, WAIT_RISE, MEASURE, ISSUE, HOLDOFF. One counter, WIDTH bits, cleared on every state entry.
- IDLE: start_in=1 → TRIG; trigger_out=1 from next cycle.
- TRIG: trigger_out held high exactly TRIG_CYCLES cycles → WAIT_RISE, trigger_out=0.
- WAIT_RISE:
  - On a synchronized rising edge (sync=1, previous=0): counter=1 → MEASURE.
  - If counter reaches TIMEOUT_CYCLES first: timeout_out pulse → HOLDOFF.
  - An echo already high on entry is not a rise; wait for it to drop and rise again.
- MEASURE:
  - While sync=1: counter+1.
  - If counter reaches TIMEOUT_CYCLES while still high: timeout_out pulse → HOLDOFF; tof_cycles_out unchanged.
  - On sync=0: latch counter into tof_cycles_out and div_dividend_out → ISSUE.
- ISSUE:
  - Wait while div_busy_in=1.
  - First cycle with div_busy_in=0: div_valid_out=1 for exactly one cycle → HOLDOFF.
- HOLDOFF: count HOLDOFF_CYCLES → IDLE. start_in is ignored in every non-IDLE state; no queuing.
- Arithmetic and widths:
  - Counters are unsigned and never wrap; timeout fires before overflow. Require TIMEOUT_CYCLES < 2^WIDTH.
  - div_divisor_out is constant CYCLES_PER_CM, zero-extended to WIDTH.

## Timing
- All outputs registered. Reset values: trigger_out, div_valid_out, timeout_out, busy_out = 0; div_dividend_out, tof_cycles_out = 0; div_divisor_out = CYCLES_PER_CM. State = IDLE.
- Reset mid-operation: outputs take reset values at the next clk edge, including an in-flight trigger or valid. The synchronizer flops also clear.
- start_in sampled high at edge k → trigger_out high over cycles k+1 … k+TRIG_CYCLES.
- echo_in to internal sync: 2 cycles latency. Measured count equals the number of cycles echo_in was held high, for a clock-aligned echo.
- Divider handshake: the divider samples the strobe only while not busy and raises busy on the following cycle. div_valid_out is never asserted while div_busy_in=1. Dividend and divisor are stable from the cycle before the strobe until the next measurement.
- Simultaneous events:
  - Echo falling on the same cycle the counter hits TIMEOUT_CYCLES counts as a valid measurement (fall has priority).
  - start_in during HOLDOFF's last cycle is ignored.

## Structure
- Shared package sonar_pkg: state enum type for the echo timer; default constants CYCLES_PER_CM, TRIG_CYCLES, TIMEOUT_CYCLES, HOLDOFF_CYCLES.
- Sub-module sync_2ff: parameterless 2-flop synchronizer for echo_in, with synchronous active-low reset. Reused by other async sensor inputs.
- Edge detection and FSM live in echo_timer.

## Test plan
Bench parameters: TRIG_CYCLES=4, TIMEOUT_CYCLES=50, HOLDOFF_CYCLES=10, CYCLES_PER_CM=3, WIDTH=16. Divider instantiated downstream.
- start_in pulse at cycle 0 → trigger_out high cycles 1–4 exactly; busy_out high from cycle 1.
- Echo high 30 clock-aligned cycles → tof_cycles_out=30; one div_valid_out with dividend=30, divisor=3; divider quotient_out=10, remainder_out=0.
- No echo after trigger → timeout_out single pulse 50 cycles after WAIT_RISE entry; no div_valid_out; IDLE after 10 holdoff cycles.
- Echo held high 80 cycles → timeout_out at count 50; tof_cycles_out keeps prior value; no strobe.
- div_busy_in forced high for 20 cycles at ISSUE → div_valid_out stays low, then exactly one pulse the first cycle busy drops.
- rst_n_in low during MEASURE, plus start_in pulses during HOLDOFF → all outputs at reset values next edge; HOLDOFF starts are ignored, with no trigger until a start in IDLE.
